// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'b000,
    StStart  = 3'b001,
    StData   = 3'b010,
    StParity = 3'b011,
    StStop   = 3'b100
  } uart_state_e;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  // Unused upper data bits must be zero so they do not disturb the XOR.
  function automatic logic calc_parity(logic [8:0] data, logic [1:0] mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Synchronous show-ahead FIFO holding each queued word together with its parity mode.
module uart_tx_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [Width-1:0]           wdata,
  output logic [Width-1:0]           rdata,
  output logic [$clog2(Depth):0]     count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign do_push = push && (count_q != CntW'(Depth));
  assign do_pop  = pop && (count_q != '0);

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO, configurable word length and stop bits.
// Parity generation is built only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_RATE   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  input  logic [1:0]                    parity_mode,
  output logic                          tx,
  output logic                          busy,
  output logic [2:0]                    state_bits,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned Cpb        = CLK_RATE / BAUD_RATE;
  localparam int unsigned CntW       = $clog2(Cpb);
  localparam int unsigned IdxW       = $clog2(DATA_BITS + 1);
  localparam int unsigned StopCycles = STOP_BITS * Cpb;
  localparam int unsigned StopW      = $clog2(StopCycles);
  localparam int unsigned WordW      = DATA_BITS + 2;
  localparam int unsigned FcW        = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CntW-1:0]  CntMax  = CntW'(Cpb - 1);
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(DATA_BITS - 1);
  localparam logic [StopW-1:0] StopMax = StopW'(StopCycles - 1);

  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [StopW-1:0]     stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 pop, push, bit_done;
  logic [WordW-1:0]     fifo_rdata;
  logic [FcW-1:0]       count;

  assign push     = data_valid && data_ready;
  assign bit_done = (cnt_q == CntMax);

  uart_tx_fifo_mem #(
    .Width (WordW),
    .Depth (FIFO_DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({parity_mode, data_in}),
    .rdata (fifo_rdata),
    .count (count)
  );

`ifdef UART_TX_PARITY_EN
  logic       par_en_q, par_en_d;
  logic       par_bit_q, par_bit_d;
  logic [1:0] word_mode;

  assign word_mode = fifo_rdata[DATA_BITS+1:DATA_BITS];
`else
  logic [1:0] unused_mode;

  assign unused_mode = fifo_rdata[DATA_BITS+1:DATA_BITS];
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif

    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (count != '0) pop = 1'b1;
      end
      StStart: begin
        cnt_d = cnt_q + CntW'(1);
        if (bit_done) begin
          state_d = StData;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        cnt_d = cnt_q + CntW'(1);
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == IdxLast) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = StParity;
              tx_d    = par_bit_q;
            end else begin
              state_d    = StStop;
              tx_d       = 1'b1;
              stop_cnt_d = '0;
            end
`else
            state_d    = StStop;
            tx_d       = 1'b1;
            stop_cnt_d = '0;
`endif
          end else begin
            idx_d   = idx_q + IdxW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        cnt_d = cnt_q + CntW'(1);
        if (bit_done) begin
          state_d    = StStop;
          cnt_d      = '0;
          tx_d       = 1'b1;
          stop_cnt_d = '0;
        end
      end
`endif
      StStop: begin
        stop_cnt_d = stop_cnt_q + StopW'(1);
        if (stop_cnt_q == StopMax) begin
          // Back-to-back path: the next start bit follows the last stop cycle directly.
          if (count != '0) begin
            pop = 1'b1;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    if (pop) begin
      state_d = StStart;
      cnt_d   = '0;
      tx_d    = 1'b0;
      shift_d = fifo_rdata[DATA_BITS-1:0];
`ifdef UART_TX_PARITY_EN
      par_en_d  = (word_mode == PARITY_EVEN) || (word_mode == PARITY_ODD);
      par_bit_d = calc_parity(9'(fifo_rdata[DATA_BITS-1:0]), word_mode);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_cnt_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign state_bits = state_q;
  assign fifo_count = count;
  assign data_ready = (count != FcW'(FIFO_DEPTH));
  assign busy       = (state_q != StIdle) || (count != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: per-cycle line/queue reference model plus directed checks.
module tb_uart_tx_fifo;

  localparam int unsigned CPB   = 10;
  localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a_valid = 1'b0;
  logic [7:0] a_data  = 8'h00;
  logic [1:0] a_mode  = 2'b00;
  logic       a_ready, a_tx, a_busy;
  logic [2:0] a_state;
  logic [2:0] a_count;

  logic       b_valid = 1'b0;
  logic [6:0] b_data  = 7'h00;
  logic [1:0] b_mode  = 2'b00;
  logic       b_ready, b_tx, b_busy;
  logic [2:0] b_state;
  logic [2:0] b_count;

  int tests = 0;
  int fails = 0;

  // Reference model: queued words and the expected per-cycle {state, tx} of the line.
  logic [9:0] mq[$];
  logic [3:0] lq[$];
  bit         in_frame = 1'b0;
  logic       m_tx     = 1'b1;
  logic [2:0] m_state  = 3'd0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_RATE   (50000000),
    .BAUD_RATE  (5000000),
    .DATA_BITS  (8),
    .STOP_BITS  (1),
    .FIFO_DEPTH (DEPTH)
  ) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .data_in     (a_data),
    .data_valid  (a_valid),
    .data_ready  (a_ready),
    .parity_mode (a_mode),
    .tx          (a_tx),
    .busy        (a_busy),
    .state_bits  (a_state),
    .fifo_count  (a_count)
  );

  uart_tx_fifo #(
    .CLK_RATE   (50000000),
    .BAUD_RATE  (5000000),
    .DATA_BITS  (7),
    .STOP_BITS  (2),
    .FIFO_DEPTH (DEPTH)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .data_in     (b_data),
    .data_valid  (b_valid),
    .data_ready  (b_ready),
    .parity_mode (b_mode),
    .tx          (b_tx),
    .busy        (b_busy),
    .state_bits  (b_state),
    .fifo_count  (b_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input logic [9:0] w);
    logic [7:0] d;
    logic [1:0] m;
    bit         par_on, par;
    d      = w[7:0];
    m      = w[9:8];
    par_on = PAR_BUILT && (m == 2'b01 || m == 2'b10);
    par    = (($countones(d) % 2) == 1) ^ (m == 2'b10);
    repeat (CPB) lq.push_back({3'd1, 1'b0});
    for (int b = 0; b < 8; b++) repeat (CPB) lq.push_back({3'd2, d[b]});
    if (par_on) repeat (CPB) lq.push_back({3'd3, par});
    repeat (CPB) lq.push_back({3'd4, 1'b1});
  endtask

  // One clock: advance the model with the inputs the DUT sampled, then compare DUT A.
  task automatic tick();
    bit         acc;
    logic [3:0] e;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      lq.delete();
      in_frame = 1'b0;
      m_tx     = 1'b1;
      m_state  = 3'd0;
    end else begin
      acc = a_valid && (mq.size() != DEPTH);
      if (lq.size() == 0 && mq.size() != 0) add_frame(mq.pop_front());
      if (lq.size() != 0) begin
        e = lq.pop_front();
        {m_state, m_tx} = e;
        in_frame = 1'b1;
      end else begin
        in_frame = 1'b0;
        m_tx     = 1'b1;
        m_state  = 3'd0;
      end
      if (acc) mq.push_back({a_mode, a_data});
    end
    #1;
    check("tx", 32'(a_tx), 32'(m_tx));
    check("state_bits", 32'(a_state), 32'(m_state));
    check("busy", 32'(a_busy), 32'(in_frame || mq.size() != 0));
    check("fifo_count", 32'(a_count), 32'(mq.size()));
    check("data_ready", 32'(a_ready), 32'(mq.size() != DEPTH));
  endtask

  initial begin
    logic [7:0] wl [6];
    logic [6:0] bw;
    int         pi, frame, bidx;
    logic       rdy, exp_b;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_tx", 32'(a_tx), 32'd1);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_count", 32'(a_count), 32'd0);
    check("rst_state", 32'(a_state), 32'd0);
    rst = 1'b0;
    tick();

    // 8N1 frame of 0x55
    a_valid = 1'b1; a_data = 8'h55; a_mode = 2'b00;
    tick();
    a_valid = 1'b0;
    for (int off = 0; off <= 100; off++) begin
      tick();
      if (off == 0)   check("x55_start_fall", 32'(a_tx), 32'd0);
      if (off == 9)   check("x55_start_end", 32'(a_tx), 32'd0);
      if (off == 15)  check("x55_bit0", 32'(a_tx), 32'd1);
      if (off == 25)  check("x55_bit1", 32'(a_tx), 32'd0);
      if (off == 85)  check("x55_bit7", 32'(a_tx), 32'd0);
      if (off == 95)  check("x55_stop", 32'(a_tx), 32'd1);
      if (off == 99)  check("x55_busy_last", 32'(a_busy), 32'd1);
      if (off == 100) check("x55_busy_fall", 32'(a_busy), 32'd0);
    end

    // 0x07 with even then odd parity request
    frame = PAR_BUILT ? 110 : 100;
    for (int pm = 1; pm <= 2; pm++) begin
      a_valid = 1'b1; a_data = 8'h07; a_mode = 2'(pm);
      tick();
      a_valid = 1'b0;
      for (int off = 0; off <= frame; off++) begin
        tick();
        if (off == 95)
          check("x07_bit95", 32'(a_tx), (PAR_BUILT && pm == 2) ? 32'd0 : 32'd1);
        if (off == frame - 1) check("x07_busy_last", 32'(a_busy), 32'd1);
        if (off == frame)     check("x07_busy_fall", 32'(a_busy), 32'd0);
      end
    end
    a_mode = 2'b00;

    // Overflow: six words offered with valid held high
    wl = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    pi = 0;
    for (int c = 0; c < 30; c++) begin
      rdy     = a_ready;
      a_valid = (pi < 6);
      a_data  = wl[pi % 6];
      tick();
      if (a_valid && rdy) pi++;
    end
    check("ovf_accepted", 32'(pi), 32'd5);
    check("ovf_ready_low", 32'(a_ready), 32'd0);
    check("ovf_count_full", 32'(a_count), 32'd4);
    for (int c = 0; c < 1500 && (pi < 6 || in_frame || mq.size() != 0); c++) begin
      rdy     = a_ready;
      a_valid = (pi < 6);
      a_data  = wl[pi % 6];
      tick();
      if (a_valid && rdy) pi++;
    end
    a_valid = 1'b0;
    check("ovf_all_accepted", 32'(pi), 32'd6);
    check("ovf_drained", 32'(a_busy), 32'd0);

    // DUT B: 7 data bits, 2 stop bits, word 0x41
    bw = 7'h41;
    b_valid = 1'b1; b_data = bw;
    tick();
    b_valid = 1'b0;
    for (int off = 0; off <= 100; off++) begin
      tick();
      if (off < 100) begin
        bidx  = off / 10;
        exp_b = (bidx == 0) ? 1'b0 : (bidx <= 7) ? bw[bidx-1] : 1'b1;
        check("b_tx", 32'(b_tx), 32'(exp_b));
      end
      if (off == 75) check("b_state_data", 32'(b_state), 32'd2);
      if (off == 85) check("b_state_stop", 32'(b_state), 32'd4);
      if (off == 99) check("b_busy_last", 32'(b_busy), 32'd1);
      if (off == 100) begin
        check("b_idle_state", 32'(b_state), 32'd0);
        check("b_idle_busy", 32'(b_busy), 32'd0);
      end
    end

    // Reset mid-frame during the 4th data bit with two words queued
    a_valid = 1'b1; a_data = 8'h11;
    tick();
    a_data = 8'h22;
    tick();
    a_data = 8'h33;
    tick();
    a_valid = 1'b0;
    repeat (43) tick();
    check("mid_queued", 32'(a_count), 32'd2);
    check("mid_state", 32'(a_state), 32'd2);
    rst = 1'b1;
    tick();
    check("mrst_tx", 32'(a_tx), 32'd1);
    check("mrst_busy", 32'(a_busy), 32'd0);
    check("mrst_count", 32'(a_count), 32'd0);
    check("mrst_state", 32'(a_state), 32'd0);
    check("mrst_ready", 32'(a_ready), 32'd1);
    rst = 1'b0;
    repeat (5) tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      a_valid = ($urandom_range(0, 3) == 0);
      a_data  = 8'($urandom);
      a_mode  = 2'($urandom_range(0, 3));
      tick();
    end
    a_valid = 1'b0;
    for (int c = 0; c < 2000 && (in_frame || mq.size() != 0); c++) tick();
    tick();
    check("rand_drained", 32'(a_busy), 32'd0);
    check("b_final_ready", 32'(b_ready), 32'd1);
    check("b_final_count", 32'(b_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
